// File: rtl/prog_loader_pkg.sv
// Shared constants for the UART program loader: FSM encodings and parameter defaults.
package prog_loader_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/prog_loader_if.sv
// Loader-side bus: BRAM port B writes, CPU control, status and FSM state for observation.
interface prog_loader_if #(parameter int ADDR_W = 11);

    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              cpu_hold;
    logic              cpu_restart;
    logic              load_done;
    logic              load_err;
    logic [7:0]        byte_cnt;
    logic [2:0]        state;
    logic [1:0]        rx_state;

    modport master (
        output ram_addr, ram_data, ram_we, cpu_hold, cpu_restart,
               load_done, load_err, byte_cnt, state, rx_state
    );

    modport slave (
        input ram_addr, ram_data, ram_we, cpu_hold, cpu_restart,
              load_done, load_err, byte_cnt, state, rx_state
    );

endinterface

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, false-start rejection, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic [1:0] state
);

    localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // byte_valid is a single-cycle strobe; data and frame_err are valid with it and
    // hold until the next strobe. There is no back-pressure: the consumer must take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == FULL) begin
                        byte_valid <= 1'b1;
                        data       <= shreg;
                        frame_err  <= !rx_sync;
                        state      <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed image (sync, length, data, checksum) from UART into program BRAM,
// holding the CPU during the load and restarting it on a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int          ADDR_W       = 11,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [23:0] TIMEOUT_CYC  = 24'd5_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    prog_loader_if.master  bus
);

    logic        byte_valid, frame_err;
    logic [7:0]  rx_data;
    logic [1:0]  rx_state;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .data       (rx_data),
        .frame_err  (frame_err),
        .state      (rx_state)
    );

    logic [2:0]        state;
    logic [8:0]        remain;
    logic [7:0]        csum, byte_cnt, ram_data;
    logic [23:0]       idle_cnt;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we, cpu_hold, cpu_restart, load_done, load_err;
    logic              in_frame, timeout;

    assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign timeout  = (idle_cnt == TIMEOUT_CYC - 24'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            remain      <= '0;
            csum        <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_we      <= 1'b0;
            cpu_hold    <= 1'b0;
            cpu_restart <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            cpu_restart <= 1'b0;
            idle_cnt    <= (byte_valid || !in_frame) ? 24'd0 : idle_cnt + 24'd1;
            case (state)
                ST_IDLE: begin
                    // Framing errors and non-sync bytes between frames are ignored.
                    if (byte_valid && !frame_err && rx_data == SYNC_BYTE) begin
                        state     <= ST_LEN;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        byte_cnt  <= '0;
                        csum      <= '0;
                    end
                end
                ST_LEN: begin
                    if (byte_valid) begin
                        if (frame_err) begin
                            state <= ST_ERR;
                        end else begin
                            remain <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                            state  <= ST_DATA;
                        end
                    end else if (timeout) begin
                        state <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (byte_valid) begin
                        if (frame_err) begin
                            state <= ST_ERR;
                        end else begin
                            ram_we   <= 1'b1;
                            ram_data <= rx_data;
                            ram_addr <= {{(ADDR_W-8){1'b0}}, byte_cnt};
                            csum     <= csum + rx_data;
                            // A 256-byte image leaves byte_cnt wrapped back to 0.
                            byte_cnt <= byte_cnt + 8'd1;
                            remain   <= remain - 9'd1;
                            if (remain == 9'd1) state <= ST_CSUM;
                        end
                    end else if (timeout) begin
                        state <= ST_ERR;
                    end
                end
                ST_CSUM: begin
                    if (byte_valid) begin
                        if (!frame_err && rx_data == csum) begin
                            state       <= ST_DONE;
                            load_done   <= 1'b1;
                            cpu_restart <= 1'b1;
                            cpu_hold    <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                        end
                    end else if (timeout) begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    // cpu_hold is left high so a partial image never runs.
                    load_err <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_addr    = ram_addr;
    assign bus.ram_data    = ram_data;
    assign bus.ram_we      = ram_we;
    assign bus.cpu_hold    = cpu_hold;
    assign bus.cpu_restart = cpu_restart;
    assign bus.load_done   = load_done;
    assign bus.load_err    = load_err;
    assign bus.byte_cnt    = byte_cnt;
    assign bus.state       = state;
    assign bus.rx_state    = rx_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven frames, hand-written corner cases, random frames vs a frame-parsing model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CPB    = 16;
  localparam int ADDR_W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  prog_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (ADDR_W),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CYC  (24'd2000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_rs   = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic prev_we = 1'b0, prev_hold = 1'b0, prev_rs = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        n_wr++;
        chk("we_single_cycle", int'(prev_we), 0);
        chk("hold_during_write", int'(bus.cpu_hold), 1);
        chk("we_vs_restart", int'(bus.cpu_restart), 0);
        chk("write_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          chk("write_addr_data", int'({bus.ram_addr, bus.ram_data}), int'(exp_q.pop_front()));
      end
      if (bus.cpu_restart) begin
        n_rs++;
        chk("restart_single_cycle", int'(prev_rs), 0);
        chk("restart_hold_release", int'({prev_hold, bus.cpu_hold}), 2);
      end
    end
    prev_we   <= bus.ram_we;
    prev_hold <= bus.cpu_hold;
    prev_rs   <= bus.cpu_restart;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
  endtask

  // Reference: parse the byte stream by the frame rules (sync, length, data, checksum).
  task automatic model_frame(output bit done, output int cnt, output int nwr);
    int i = 0;
    int n;
    int sum = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    n = (frame_q[i+1] == 8'h00) ? 256 : int'(frame_q[i+1]);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({ADDR_W'(k), frame_q[i+2+k]});
      sum += int'(frame_q[i+2+k]);
    end
    done = ((sum % 256) == int'(frame_q[i+2+n]));
    cnt  = n % 256;
    nwr  = n;
  endtask

  task automatic run_check(input string tag, input bit done, input int cnt, input int nwr);
    int wr0 = n_wr;
    int rs0 = n_rs;
    send_frame();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({tag, "_load_done"}, int'(bus.load_done), int'(done));
    chk({tag, "_load_err"}, int'(bus.load_err), int'(!done));
    chk({tag, "_cpu_hold"}, int'(bus.cpu_hold), int'(!done));
    chk({tag, "_byte_cnt"}, int'(bus.byte_cnt), cnt);
    chk({tag, "_writes"}, n_wr - wr0, nwr);
    chk({tag, "_restarts"}, n_rs - rs0, done ? 1 : 0);
    chk({tag, "_exp_q_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0][7:0] b;   // b[0] is sent first
    int              n;
    bit              done;
    int              cnt;
    int              nwr;
    string           tag;
  } vec_t;

  vec_t vt[4];

  task automatic play_vec(input int idx);
    bit md;
    int mc, mn;
    frame_q.delete();
    for (int j = 0; j < vt[idx].n; j++) frame_q.push_back(vt[idx].b[j]);
    model_frame(md, mc, mn);
    run_check(vt[idx].tag, vt[idx].done, vt[idx].cnt, vt[idx].nwr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wr0;
    bit md;
    int mc, mn;
    logic [7:0] b;
    int sum;

    vt[0] = '{b: {8'h00, 8'h00, 8'h66, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5}, n: 6, done: 1, cnt: 3, nwr: 3, tag: "good"};
    vt[1] = '{b: {8'h00, 8'h00, 8'h00, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hA5}, n: 5, done: 0, cnt: 2, nwr: 2, tag: "bad_csum"};
    vt[2] = '{b: {8'h00, 8'h00, 8'h66, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5}, n: 6, done: 1, cnt: 3, nwr: 3, tag: "good_after_err"};
    vt[3] = '{b: {8'h00, 8'h00, 8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h42, 8'h00}, n: 6, done: 1, cnt: 1, nwr: 1, tag: "noise_sync_data"};

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_we", int'(bus.ram_we), 0);
    chk("rst_ram_addr", int'(bus.ram_addr), 0);
    chk("rst_cpu_hold", int'(bus.cpu_hold), 0);
    chk("rst_cpu_restart", int'(bus.cpu_restart), 0);
    chk("rst_load_done", int'(bus.load_done), 0);
    chk("rst_load_err", int'(bus.load_err), 0);
    chk("rst_byte_cnt", int'(bus.byte_cnt), 0);
    chk("rst_state", int'(bus.state), int'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int v = 0; v < 4; v++) play_vec(v);

    // Timeout after one data byte.
    wr0 = n_wr;
    exp_q.push_back({ADDR_W'(0), 8'h10});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (2100) @(posedge clk);
    @(negedge clk);
    chk("timeout_load_err", int'(bus.load_err), 1);
    chk("timeout_load_done", int'(bus.load_done), 0);
    chk("timeout_cpu_hold", int'(bus.cpu_hold), 1);
    chk("timeout_byte_cnt", int'(bus.byte_cnt), 1);
    chk("timeout_writes", n_wr - wr0, 1);

    // Framing error in DATA, then a short glitch while idle.
    wr0 = n_wr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("frame_err_load_err", int'(bus.load_err), 1);
    chk("frame_err_cpu_hold", int'(bus.cpu_hold), 1);
    chk("frame_err_byte_cnt", int'(bus.byte_cnt), 0);
    chk("frame_err_writes", n_wr - wr0, 0);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("glitch_state", int'(bus.state), int'(ST_IDLE));
    chk("glitch_rx_state", int'(bus.rx_state), int'(RX_IDLE));
    chk("glitch_load_err", int'(bus.load_err), 1);
    chk("glitch_writes", n_wr - wr0, 0);
    play_vec(0);

    // Reset after two of five data bytes.
    wr0 = n_wr;
    exp_q.push_back({ADDR_W'(0), 8'h12});
    exp_q.push_back({ADDR_W'(1), 8'h34});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ram_we", int'(bus.ram_we), 0);
    chk("midrst_cpu_hold", int'(bus.cpu_hold), 0);
    chk("midrst_load_done", int'(bus.load_done), 0);
    chk("midrst_load_err", int'(bus.load_err), 0);
    chk("midrst_byte_cnt", int'(bus.byte_cnt), 0);
    chk("midrst_ram_addr", int'(bus.ram_addr), 0);
    rst = 1'b0;
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hE2, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_writes", n_wr - wr0, 2);
    chk("midrst_hold_after", int'(bus.cpu_hold), 0);
    chk("midrst_restarts_none", int'(bus.load_done), 0);

    // Random frames with noise, random payloads and occasional bad checksums.
    for (int r = 0; r < 8; r++) begin
      frame_q.delete();
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        b = 8'($urandom_range(0, 255));
        frame_q.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      frame_q.push_back(8'hA5);
      b = 8'($urandom_range(1, 6));
      frame_q.push_back(b);
      sum = 0;
      for (int k = 0; k < int'(b); k++) begin
        frame_q.push_back(8'($urandom_range(0, 255)));
        sum += int'(frame_q[frame_q.size()-1]);
      end
      if ($urandom_range(0, 3) == 0) sum += 1;
      frame_q.push_back(8'(sum));
      model_frame(md, mc, mn);
      run_check($sformatf("rand%0d", r), md, mc, mn);
    end

    // Length byte 0 means a full 256-byte image; byte_cnt wraps to 0.
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h00);
    sum = 0;
    for (int k = 0; k < 256; k++) begin
      frame_q.push_back(8'((k * 7 + 3) & 255));
      sum += (k * 7 + 3) & 255;
    end
    frame_q.push_back(8'(sum));
    model_frame(md, mc, mn);
    run_check("len256", 1'b1, 0, 256);

    chk("final_exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
